// File: rtl/approx_mul8_seq_sched.sv
// Time-multiplexes one 4x4 approximate sub-multiplier to serve two 8x8 requesters (LL, LH, HL, HH passes).
// Optional macro APPROX_MUL_SKIP_ZERO_EN: passes whose nibble operands include a zero are skipped.
module approx_mul8_seq_sched #(
  parameter logic [1:0] MODE_LL = 2'd0,
  parameter logic [1:0] MODE_LH = 2'd0,
  parameter logic [1:0] MODE_HL = 2'd0,
  parameter logic [1:0] MODE_HH = 2'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic        mul_en,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  output logic [1:0]  mul_mode,
  input  logic [7:0]  mul_prod,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_prod
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_r, state_s;
  logic [1:0]  pass_r, pass_s;
  logic [7:0]  a_r, a_s, b_r, b_s;
  logic        id_r, id_s;
  logic        last_id_r, last_id_s;
  logic [15:0] acc_r, acc_s;
  logic        grant0_s, grant1_s;
  logic        mul_en_s;
  logic [3:0]  nib_a_s, nib_b_s;
  logic [1:0]  mode_s;
  logic [15:0] term_s;

`ifdef APPROX_MUL_SKIP_ZERO_EN
  // live_r low marks the first RUN cycle, used only to locate the first useful pass
  logic        live_r, live_s;
  logic [2:0]  first_s, next_s;

  function automatic logic [2:0] find_pass(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] start);
    logic [2:0] res;
    logic [1:0] q;
    res = 3'd0;
    for (int p = 3; p >= 0; p--) begin
      q = p[1:0];
      if (({1'b0, q} >= start) && ((q[1] ? a[7:4] : a[3:0]) != 4'd0) &&
          ((q[0] ? b[7:4] : b[3:0]) != 4'd0)) begin
        res = {1'b1, q};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign first_s  = find_pass(a_r, b_r, 3'd0);
  assign next_s   = find_pass(a_r, b_r, {1'b0, pass_r} + 3'd1);
  assign mul_en_s = (state_r == RUN) && live_r;
`else
  assign mul_en_s = (state_r == RUN);
`endif

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign mul_en     = mul_en_s;
  assign mul_a      = mul_en_s ? nib_a_s : 4'd0;
  assign mul_b      = mul_en_s ? nib_b_s : 4'd0;
  assign mul_mode   = mul_en_s ? mode_s  : 2'd0;
  assign resp_valid = (state_r == DONE);
  assign resp_id    = id_r;
  assign resp_prod  = acc_r;

  // Round-robin grant: on a tie the requester not served last wins
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      if (req0_valid && req1_valid) begin
        grant0_s = last_id_r;
        grant1_s = ~last_id_r;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Per-pass nibble select, mode and shifted partial product
  always_comb begin
    nib_a_s = pass_r[1] ? a_r[7:4] : a_r[3:0];
    nib_b_s = pass_r[0] ? b_r[7:4] : b_r[3:0];
    mode_s  = MODE_LL;
    term_s  = 16'd0;
    case (pass_r)
      2'd0:    begin mode_s = MODE_LL; term_s = {8'd0, mul_prod};       end
      2'd1:    begin mode_s = MODE_LH; term_s = {4'd0, mul_prod, 4'd0}; end
      2'd2:    begin mode_s = MODE_HL; term_s = {4'd0, mul_prod, 4'd0}; end
      default: begin mode_s = MODE_HH; term_s = {mul_prod, 8'd0};       end
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_s   = state_r;
    pass_s    = pass_r;
    a_s       = a_r;
    b_s       = b_r;
    id_s      = id_r;
    last_id_s = last_id_r;
    acc_s     = acc_r;
`ifdef APPROX_MUL_SKIP_ZERO_EN
    live_s    = live_r;
`endif
    case (state_r)
      IDLE: begin
        if (grant0_s || grant1_s) begin
          a_s     = grant1_s ? req1_a : req0_a;
          b_s     = grant1_s ? req1_b : req0_b;
          id_s    = grant1_s;
          acc_s   = 16'd0;
          pass_s  = 2'd0;
          state_s = RUN;
`ifdef APPROX_MUL_SKIP_ZERO_EN
          live_s  = 1'b0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
`ifdef APPROX_MUL_SKIP_ZERO_EN
        if (live_r) begin
          acc_s = acc_r + term_s;
          if (next_s[2]) begin
            pass_s = next_s[1:0];
          end else begin
            live_s  = 1'b0;
            state_s = DONE;
          end
        end else begin
          if (first_s[2]) begin
            pass_s = first_s[1:0];
            live_s = 1'b1;
          end else begin
            state_s = DONE;
          end
        end
`else
        acc_s = acc_r + term_s;
        if (pass_r == 2'd3) begin
          state_s = DONE;
        end else begin
          pass_s = pass_r + 2'd1;
        end
`endif
      end
      DONE: begin
        if (resp_ready) begin
          last_id_s = id_r;
          state_s   = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and datapath registers; last_id resets to 1 so req0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pass_r    <= 2'd0;
      a_r       <= 8'd0;
      b_r       <= 8'd0;
      id_r      <= 1'b0;
      last_id_r <= 1'b1;
      acc_r     <= 16'd0;
`ifdef APPROX_MUL_SKIP_ZERO_EN
      live_r    <= 1'b0;
`endif
    end else begin
      state_r   <= state_s;
      pass_r    <= pass_s;
      a_r       <= a_s;
      b_r       <= b_s;
      id_r      <= id_s;
      last_id_r <= last_id_s;
      acc_r     <= acc_s;
`ifdef APPROX_MUL_SKIP_ZERO_EN
      live_r    <= live_s;
`endif
    end
  end

endmodule

// File: tb/tb_approx_mul8_seq_sched.sv
// Scoreboard bench for approx_mul8_seq_sched; the sub-multiplier model returns the exact 4x4 product.
module tb_approx_mul8_seq_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_a = 8'd0, req0_b = 8'd0, req1_a = 8'd0, req1_b = 8'd0;
  logic        req0_ready, req1_ready;
  logic        mul_en;
  logic [3:0]  mul_a, mul_b;
  logic [1:0]  mul_mode;
  logic [7:0]  mul_prod;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_id;
  logic [15:0] resp_prod;

  typedef struct packed {
    logic        id;
    logic [15:0] prod;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  approx_mul8_seq_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_mode(mul_mode), .mul_prod(mul_prod),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_prod(resp_prod)
  );

  always #5 clk = ~clk;

  assign mul_prod = {4'd0, mul_a} * {4'd0, mul_b};

  function automatic int model_passes(input logic [7:0] a, input logic [7:0] b);
`ifdef APPROX_MUL_SKIP_ZERO_EN
    int n;
    n = 0;
    if (a[3:0] != 4'd0 && b[3:0] != 4'd0) n++;
    if (a[3:0] != 4'd0 && b[7:4] != 4'd0) n++;
    if (a[7:4] != 4'd0 && b[3:0] != 4'd0) n++;
    if (a[7:4] != 4'd0 && b[7:4] != 4'd0) n++;
    return n;
`else
    return 4;
`endif
  endfunction

  function automatic int model_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef APPROX_MUL_SKIP_ZERO_EN
    return 1 + model_passes(a, b);
`else
    return 4;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  // Drive one request, wait for its grant, push the expected result; returns just after the accept edge
  task automatic send(input logic id, input logic [7:0] a, input logic [7:0] b);
    int          t;
    logic [15:0] p;
    t = 0;
    p = a * b;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end
    #1;
    while (!(id ? req1_ready : req0_ready) && t < 50) begin
      step();
      t++;
    end
    n_cmp++;
    if (t >= 50) begin
      n_err++;
      $display("FAIL accept_timeout id=%0d: ready actual 0, required 1", id);
    end else begin
      sb.push_back('{id, p});
    end
    step();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Wait for a response, compare it against the scoreboard and latency, then complete the handshake
  task automatic collect(input int exp_lat, output int en_cnt,
                         output logic [3:0] last_a, output logic [3:0] last_b);
    int   cnt;
    exp_t e;
    cnt = 0;
    en_cnt = 0;
    last_a = 4'd0;
    last_b = 4'd0;
    while (!resp_valid && cnt < 100) begin
      if (mul_en) begin
        en_cnt++;
        last_a = mul_a;
        last_b = mul_b;
      end else begin
        n_cmp++;
        if ({mul_a, mul_b, mul_mode} !== 10'd0) begin
          n_err++;
          $display("FAIL idle_mul_zero: actual %h, required 0", {mul_a, mul_b, mul_mode});
        end
      end
      step();
      cnt++;
    end
    n_cmp++;
    if (cnt != exp_lat) begin
      n_err++;
      $display("FAIL latency: actual %0d edges, required %0d", cnt, exp_lat);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL resp_unexpected: actual id=%0d prod=%h, required no response", resp_id, resp_prod);
    end else begin
      e = sb.pop_front();
      if ({resp_valid, resp_id, resp_prod} !== {1'b1, e.id, e.prod}) begin
        n_err++;
        $display("FAIL resp: actual v=%0d id=%0d prod=%h, required v=1 id=%0d prod=%h",
                 resp_valid, resp_id, resp_prod, e.id, e.prod);
      end
    end
    resp_ready = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [30:0] obs;
    rst_n = 1'b0;
    #1;
    obs = {req0_ready, req1_ready, mul_en, mul_a, mul_b, mul_mode, resp_valid, resp_id, resp_prod};
    n_cmp++;
    if (obs !== 31'd0) begin
      n_err++;
      $display("FAIL reset_outputs: actual %h, required 0", obs);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [3:0]  ea[4];
    logic [3:0]  eb[4];
    logic [1:0]  em[4];
    logic [10:0] obs, expv;
    ea = '{4'h5, 4'h5, 4'hA, 4'hA};
    eb = '{4'hC, 4'h3, 4'hC, 4'h3};
    em = '{2'd0, 2'd0, 2'd0, 2'd1};
    req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h3C;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_grant: actual %b, required 10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
`ifdef APPROX_MUL_SKIP_ZERO_EN
    step();
`endif
    for (int i = 0; i < 4; i++) begin
      obs  = {mul_en, mul_a, mul_b, mul_mode};
      expv = {1'b1, ea[i], eb[i], em[i]};
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL basic_pass%0d: actual en/a/b/mode %h, required %h", i, obs, expv);
      end
      step();
    end
    n_cmp++;
    if ({resp_valid, resp_id, resp_prod} !== {1'b1, 1'b0, 16'h26AC}) begin
      n_err++;
      $display("FAIL basic_resp: actual v=%0d id=%0d prod=%h, required v=1 id=0 prod=26ac",
               resp_valid, resp_id, resp_prod);
    end
    step();
    n_cmp++;
    if ({resp_valid, mul_en} !== 2'b00) begin
      n_err++;
      $display("FAIL basic_idle: actual valid/en %b, required 00", {resp_valid, mul_en});
    end
  endtask

  task automatic test_arbitration();
    int         en;
    logic [3:0] la, lb;
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'h0F;
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'hFF;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL arb_first_tie: actual %b, required 10", {req0_ready, req1_ready});
    end
    sb.push_back('{1'b0, 16'h00E1});
    step();
    req0_valid = 1'b0;
    n_cmp++;
    if (req1_ready !== 1'b0) begin
      n_err++;
      $display("FAIL arb_busy_ready: actual %b, required 0", req1_ready);
    end
    collect(model_lat(8'h0F, 8'h0F), en, la, lb);
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL arb_second: actual %b, required 01", {req0_ready, req1_ready});
    end
    sb.push_back('{1'b1, 16'hFE01});
    step();
    req1_valid = 1'b0;
    collect(model_lat(8'hFF, 8'hFF), en, la, lb);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL arb_alternate: actual %b, required 10", {req0_ready, req1_ready});
    end
    sb.push_back('{1'b0, 16'h00E1});
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    collect(model_lat(8'h0F, 8'h0F), en, la, lb);
  endtask

  task automatic test_stall();
    int          t;
    logic [16:0] hold;
    exp_t        e;
    resp_ready = 1'b0;
    send(1'b0, 8'h12, 8'h34);
    t = 0;
    while (!resp_valid && t < 100) begin
      step();
      t++;
    end
    hold = {resp_id, resp_prod};
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if ({req0_ready, req1_ready, resp_valid, resp_id, resp_prod} !== {2'b00, 1'b1, hold}) begin
        n_err++;
        $display("FAIL stall_hold cycle %0d: actual r0=%0d r1=%0d v=%0d id/prod=%h, required 0 0 1 %h",
                 i, req0_ready, req1_ready, resp_valid, {resp_id, resp_prod}, hold);
      end
    end
    e = sb.pop_front();
    n_cmp++;
    if ({resp_id, resp_prod} !== {e.id, e.prod}) begin
      n_err++;
      $display("FAIL stall_resp: actual %h, required %h", {resp_id, resp_prod}, {e.id, e.prod});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    n_cmp++;
    if ({resp_valid, mul_en} !== 2'b00) begin
      n_err++;
      $display("FAIL stall_release: actual valid/en %b, required 00", {resp_valid, mul_en});
    end
  endtask

  task automatic test_reset_mid();
    logic [30:0] obs;
    logic        seen;
    int          en;
    logic [3:0]  la, lb;
    send(1'b1, 8'h77, 8'h99);
`ifdef APPROX_MUL_SKIP_ZERO_EN
    step();
`endif
    step();
    step();
    rst_n = 1'b0;
    #1;
    sb.delete();
    obs = {req0_ready, req1_ready, mul_en, mul_a, mul_b, mul_mode, resp_valid, resp_id, resp_prod};
    n_cmp++;
    if (obs !== 31'd0) begin
      n_err++;
      $display("FAIL midreset_outputs: actual %h, required 0", obs);
    end
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (resp_valid || mul_en) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_no_resp: actual activity 1, required 0");
    end
    send(1'b0, 8'hC3, 8'h5A);
    collect(model_lat(8'hC3, 8'h5A), en, la, lb);
  endtask

  task automatic test_skip_zero();
    int         en;
    logic [3:0] la, lb;
    send(1'b0, 8'h50, 8'h0F);
    collect(model_lat(8'h50, 8'h0F), en, la, lb);
    n_cmp++;
    if (en != model_passes(8'h50, 8'h0F)) begin
      n_err++;
      $display("FAIL skip_passes: actual %0d, required %0d", en, model_passes(8'h50, 8'h0F));
    end
`ifdef APPROX_MUL_SKIP_ZERO_EN
    n_cmp++;
    if ({la, lb} !== 8'h5F) begin
      n_err++;
      $display("FAIL skip_hl_nibbles: actual %h, required 5f", {la, lb});
    end
`endif
    send(1'b1, 8'h00, 8'h37);
    collect(model_lat(8'h00, 8'h37), en, la, lb);
    n_cmp++;
    if (en != model_passes(8'h00, 8'h37)) begin
      n_err++;
      $display("FAIL skip_zero_passes: actual %0d, required %0d", en, model_passes(8'h00, 8'h37));
    end
  endtask

  task automatic test_back_to_back();
    int         en;
    logic [7:0] a, b;
    logic [3:0] la, lb;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      send(1'(i % 2), a, b);
      collect(model_lat(a, b), en, la, lb);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arbitration();
    test_stall();
    test_reset_mid();
    test_skip_zero();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
